ahb_lite_decoder: RTL and testbench

- AHB-Lite address decoder and response multiplexer between the single bus master and three slaves: boot ROM, RAM and peripheral block.
- Decodes haddr in the address phase to drive each slave's hsel.
- Registers the data-phase selection and multiplexes slave hrdata/hreadyout/hresp back to the master as hrdata/hready/hresp.
- Contains a built-in default slave that returns a two-cycle ERROR for unmapped addresses.

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_lite_decoder_if.sv | 30 +++
 rtl/ahb_default_slave.sv | 83 ++++++++
 rtl/ahb_lite_decoder.sv | 120 ++++++++++++
 tb/tb_ahb_lite_decoder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, slave count, decoder state types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

    localparam int NSLV = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Default-slave response sequencer
    typedef enum logic [1:0] {
        DS_OK   = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // One-hot data-phase owner; DEF is the built-in default slave
    typedef enum logic [3:0] {
        DSEL_S0  = 4'b0001,
        DSEL_S1  = 4'b0010,
        DSEL_S2  = 4'b0100,
        DSEL_DEF = 4'b1000
    } dsel_t;

    function automatic logic addr_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/ahb_lite_decoder_if.sv
// Bus-side signal bundle between the master, the decoder and the three slaves.
// Latency: n/a (wiring only).
// Backpressure: hready carries the muxed wait state back to the master and all slaves.
interface ahb_lite_decoder_if;
    import ahb_pkg::*;

    logic [31:0]        haddr;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [NSLV-1:0]    hsel_s;
    logic [32*NSLV-1:0] hrdata_s;
    logic [NSLV-1:0]    hreadyout_s;
    logic [NSLV-1:0]    hresp_s;
    logic [31:0]        hrdata;
    logic               hready;
    logic               hresp;

    // Decoder view: address phase in, slave responses in, selects and muxed response out
    modport slave (
        input  haddr, htrans, hwrite, hrdata_s, hreadyout_s, hresp_s,
        output hsel_s, hrdata, hready, hresp
    );

    // Environment view: drives the master request and the slave responses
    modport master (
        output haddr, htrans, hwrite, hrdata_s, hreadyout_s, hresp_s,
        input  hsel_s, hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR; optional error log (AHB_DEC_ERRLOG_EN).
// Latency: ERROR response occupies two data-phase cycles (wait, then final); IDLE/BUSY get zero-wait OKAY.
// Backpressure: inserts exactly one wait state (ds_hready=0) per unmapped active transfer.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hready,
    input  logic [1:0]  htrans,
    input  logic        nomatch,
    input  logic [31:0] haddr,
    output logic        ds_hready,
    output logic        ds_hresp
`ifdef AHB_DEC_ERRLOG_EN
    ,
    input  logic        err_clr,
    output logic        err_valid,
    output logic [31:0] err_addr
`endif
);

    ds_state_t state_q;
    ds_state_t state_d;
    logic      err_start;

    // An active transfer to an unmapped address is accepted this edge
    assign err_start = hready && htrans[1] && nomatch;

    // htrans[0] only distinguishes SEQ/NONSEQ or IDLE/BUSY, irrelevant here
    logic unused_htrans0;
    assign unused_htrans0 = htrans[0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= DS_OK;
        else        state_q <= state_d;
    end

    // Next-state: ERR1 always advances to ERR2 even if the master drops to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_OK:   if (err_start) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = err_start ? DS_ERR1 : DS_OK;
            default: state_d = DS_OK;
        endcase
    end

    // Response outputs: wait only in ERR1, ERROR in both error states
    always_comb begin
        ds_hready = 1'b1;
        ds_hresp  = HRESP_OKAY;
        case (state_q)
            DS_ERR1: begin ds_hready = 1'b0; ds_hresp = HRESP_ERROR; end
            DS_ERR2: begin ds_hready = 1'b1; ds_hresp = HRESP_ERROR; end
            default: begin ds_hready = 1'b1; ds_hresp = HRESP_OKAY;  end
        endcase
    end

`ifdef AHB_DEC_ERRLOG_EN
    logic enter_err1;
    assign enter_err1 = err_start && (state_q != DS_ERR1);

    // First error wins; a new error coincident with a clear is still captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
        end else if (enter_err1 && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_addr  <= haddr;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end
`else
    logic unused_haddr;
    assign unused_haddr = ^haddr;
`endif

endmodule

// File: rtl/ahb_lite_decoder.sv
// AHB-Lite address decoder + response mux for ROM/RAM/peripherals with built-in default slave (AHB_DEC_ERRLOG_EN adds error log).
// Latency: hsel is combinational from haddr; response mux adds zero cycles.
// Backpressure: muxed hready from the data-phase owner stalls the master and holds the data-phase select.
module ahb_lite_decoder
    import ahb_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_C000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_F000
)
(
    input  logic              clk,
    input  logic              reset,
    ahb_lite_decoder_if.slave bus
`ifdef AHB_DEC_ERRLOG_EN
    ,
    input  logic              err_clr,
    output logic              err_valid,
    output logic [31:0]       err_addr
`endif
);

    logic [NSLV-1:0] match;
    logic [NSLV-1:0] hsel;
    logic            nomatch;
    dsel_t           dsel_q;
    dsel_t           dsel_d;
    logic            hready_mux;
    logic            hresp_mux;
    logic [31:0]     hrdata_mux;
    logic            ds_hready;
    logic            ds_hresp;

    // Direction does not affect decode or response routing
    logic unused_hwrite;
    assign unused_hwrite = bus.hwrite;

    assign match[0] = addr_match(bus.haddr, S0_BASE, S0_MASK);
    assign match[1] = addr_match(bus.haddr, S1_BASE, S1_MASK);
    assign match[2] = addr_match(bus.haddr, S2_BASE, S2_MASK);
    assign nomatch  = ~|match;

    // Priority decode: lowest slave index wins on overlapping windows
    always_comb begin
        hsel   = '0;
        dsel_d = DSEL_DEF;
        if (match[0]) begin
            hsel[0] = 1'b1;
            dsel_d  = DSEL_S0;
        end else if (match[1]) begin
            hsel[1] = 1'b1;
            dsel_d  = DSEL_S1;
        end else if (match[2]) begin
            hsel[2] = 1'b1;
            dsel_d  = DSEL_S2;
        end
    end

    assign bus.hsel_s = hsel;

    // Data-phase owner advances only when the current data phase completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          dsel_q <= DSEL_DEF;
        else if (hready_mux) dsel_q <= dsel_d;
    end

    // Route the data-phase owner's response straight back to the master
    always_comb begin
        hrdata_mux = 32'h0;
        hready_mux = ds_hready;
        hresp_mux  = ds_hresp;
        case (dsel_q)
            DSEL_S0: begin
                hrdata_mux = bus.hrdata_s[31:0];
                hready_mux = bus.hreadyout_s[0];
                hresp_mux  = bus.hresp_s[0];
            end
            DSEL_S1: begin
                hrdata_mux = bus.hrdata_s[63:32];
                hready_mux = bus.hreadyout_s[1];
                hresp_mux  = bus.hresp_s[1];
            end
            DSEL_S2: begin
                hrdata_mux = bus.hrdata_s[95:64];
                hready_mux = bus.hreadyout_s[2];
                hresp_mux  = bus.hresp_s[2];
            end
            default: begin
                hrdata_mux = 32'h0;
                hready_mux = ds_hready;
                hresp_mux  = ds_hresp;
            end
        endcase
    end

    assign bus.hrdata = hrdata_mux;
    assign bus.hready = hready_mux;
    assign bus.hresp  = hresp_mux;

    ahb_default_slave u_default_slave (
        .clk       (clk),
        .reset     (reset),
        .hready    (hready_mux),
        .htrans    (bus.htrans),
        .nomatch   (nomatch),
        .haddr     (bus.haddr),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp)
`ifdef AHB_DEC_ERRLOG_EN
        ,
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr)
`endif
    );

endmodule

// File: tb/tb_ahb_lite_decoder.sv
// Self-checking bench for ahb_lite_decoder: directed test-plan steps followed by randomized traffic.
// Reference model tracks the data-phase owner and remaining error cycles from the address map.
// Optional error-log checks are active when AHB_DEC_ERRLOG_EN is defined.
module tb_ahb_lite_decoder;

    logic clk;
    logic reset;
    int   ncmp;
    int   nfail;

    ahb_lite_decoder_if bus();

`ifdef AHB_DEC_ERRLOG_EN
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
`endif

    ahb_lite_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef AHB_DEC_ERRLOG_EN
        ,
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          m_dp;        // data-phase owner: 0..2 slave, 3 default slave
    int          m_err_left;  // 2: first ERROR cycle pending, 1: final ERROR cycle, 0: none
    logic        m_lv;
    logic [31:0] m_la;

    // Address map expressed as half-open ranges
    function automatic int decode_ref(input logic [31:0] a);
        if (a < 32'h0000_4000) return 0;
        if (a >= 32'h2000_0000 && a < 32'h2001_0000) return 1;
        if (a >= 32'h4000_0000 && a < 32'h4000_1000) return 2;
        return 3;
    endfunction

    function automatic logic exp_ready();
        if (m_dp < 3) return bus.hreadyout_s[m_dp];
        return (m_err_left != 2);
    endfunction

    task automatic model_reset();
        m_dp = 3; m_err_left = 0; m_lv = 1'b0; m_la = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          t;
        logic [2:0]  e_sel;
        logic [31:0] e_rd;
        logic        e_rsp;
        t     = decode_ref(bus.haddr);
        e_sel = (t < 3) ? 3'(1 << t) : 3'b000;
        if (m_dp < 3) begin
            e_rd  = bus.hrdata_s[32*m_dp +: 32];
            e_rsp = bus.hresp_s[m_dp];
        end else begin
            e_rd  = 32'h0;
            e_rsp = (m_err_left != 0);
        end
        chk("hsel_s", {29'b0, bus.hsel_s}, {29'b0, e_sel});
        chk("hrdata", bus.hrdata, e_rd);
        chk("hready", {31'b0, bus.hready}, {31'b0, exp_ready()});
        chk("hresp",  {31'b0, bus.hresp},  {31'b0, e_rsp});
`ifdef AHB_DEC_ERRLOG_EN
        chk("err_valid", {31'b0, err_valid}, {31'b0, m_lv});
        chk("err_addr",  err_addr, m_la);
`endif
    endtask

    task automatic model_edge();
        logic rdy;
        logic clr;
        int   tgt;
        logic act;
        rdy = exp_ready();
        tgt = decode_ref(bus.haddr);
        act = bus.htrans[1];
`ifdef AHB_DEC_ERRLOG_EN
        clr = err_clr;
`else
        clr = 1'b0;
`endif
        if (rdy && tgt == 3 && act && (!m_lv || clr)) begin
            m_lv = 1'b1;
            m_la = bus.haddr;
        end else if (clr) begin
            m_lv = 1'b0;
        end
        if (rdy) begin
            m_dp       = tgt;
            m_err_left = (tgt == 3 && act) ? 2 : 0;
        end else if (m_dp == 3 && m_err_left == 2) begin
            m_err_left = 1;
        end
    endtask

    // One bus cycle: check settled outputs mid-cycle, advance model on the edge
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t,
                         input logic [2:0] rdy, input logic [2:0] rsp);
        bus.haddr       = a;
        bus.htrans      = t;
        bus.hwrite      = 1'($urandom);
        bus.hreadyout_s = rdy;
        bus.hresp_s     = rsp;
        bus.hrdata_s    = {$urandom, $urandom, $urandom};
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = {18'h0, 14'($urandom)};
            1: a = 32'h2000_0000 | {16'h0, 16'($urandom)};
            2: a = 32'h4000_0000 | {20'h0, 12'($urandom)};
            3: a = 32'h0000_3FFC;
            4: a = 32'h0000_4000;
            5: a = 32'h2000_FFFC;
            6: a = 32'h2001_0000;
            7: a = 32'h4000_0FFC;
            8: a = 32'h4000_1000;
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        ncmp  = 0;
        nfail = 0;
        model_reset();
`ifdef AHB_DEC_ERRLOG_EN
        err_clr = 1'b0;
`endif
        // Reset state with IDLE on the bus
        reset = 1'b0;
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        #3;
        check_outputs();
        chk("rst_hready", {31'b0, bus.hready}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        model_edge();

        // NONSEQ read to ROM
        drive(32'h0000_0010, 2'b10, 3'b111, 3'b000);
        cycle();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        bus.hrdata_s[31:0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("rom_rdata", bus.hrdata, 32'hDEADBEEF);
        check_outputs();
        @(posedge clk); model_edge(); #1;

        // RAM transfer stalled two cycles, then peripheral transfer
        drive(32'h2000_0004, 2'b10, 3'b111, 3'b000);
        cycle();
        drive(32'h4000_0000, 2'b10, 3'b101, 3'b000);
        cycle();
        drive(32'h4000_0000, 2'b10, 3'b101, 3'b000);
        cycle();
        drive(32'h4000_0000, 2'b10, 3'b111, 3'b000);
        cycle();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        chk("s2_owner", {31'b0, 1'(m_dp == 2)}, 32'h1);
        cycle();

        // Unmapped NONSEQ -> two-cycle ERROR; IDLE to same address -> OKAY
        drive(32'h8000_0000, 2'b10, 3'b111, 3'b000);
        cycle();
        drive(32'h8000_0000, 2'b10, 3'b111, 3'b000);
        cycle();                                     // ERR1
        drive(32'h8000_0000, 2'b00, 3'b111, 3'b000);
        cycle();                                     // ERR2
        drive(32'h8000_0000, 2'b00, 3'b111, 3'b000);
        cycle();                                     // IDLE data phase OKAY

        // Back-to-back unmapped transfers, second issued in the final ERROR cycle
        drive(32'h9000_0000, 2'b10, 3'b111, 3'b000);
        cycle();
        drive(32'h9000_0000, 2'b00, 3'b111, 3'b000);  // master drops to IDLE during ERR1
        cycle();
        drive(32'hA000_0000, 2'b10, 3'b111, 3'b000);
        cycle();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        cycle();
        cycle();
        cycle();

`ifdef AHB_DEC_ERRLOG_EN
        chk("log_first", err_addr, 32'h9000_0000);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        cycle();
        chk("log_clr", {31'b0, err_valid}, 32'h0);
`endif

        // Reset asserted while the default slave is in its first ERROR cycle
        drive(32'hB000_0000, 2'b10, 3'b111, 3'b000);
        cycle();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        chk("pre_rst_hready", {31'b0, bus.hready}, 32'h0);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("mid_rst_hresp", {31'b0, bus.hresp}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        model_edge();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(rand_addr(), 2'($urandom),
                  {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                  {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
`ifdef AHB_DEC_ERRLOG_EN
            err_clr = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
